control_unit: RTL and testbench

- Main instruction decoder of the core.
- Takes the 3-bit major opcode `op`, `func3` and `func11` fields and produces datapath control: register/memory write enables, jump controls, ALU operation, operand selects, immediate format and result mux select.
- Decode is combinational into a one-stage output register clocked by `clk`, so controls appear one cycle after the fields are presented.
- Sits between instruction fetch/register and the execute datapath.

---
 rtl/core_pkg.sv | 67 ++++++
 rtl/control_unit_alu_decoder.sv | 32 +++
 rtl/control_unit.sv | 135 +++++++++++++
 tb/tb_control_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared decode types for the core: opcodes, ALU/immediate/result encodings.
// CU_ILLEGAL_DETECT_EN adds an illegal-instruction flag to the control bundle.
package core_pkg;

  localparam logic [2:0] OP_A = 3'b000;
  localparam logic [2:0] OP_B = 3'b001;
  localparam logic [2:0] OP_C = 3'b010;
  localparam logic [2:0] OP_D = 3'b011;
  localparam logic [2:0] OP_F = 3'b100;
  localparam logic [2:0] OP_E = 3'b101;
  localparam logic [2:0] OP_G = 3'b110;
  localparam logic [2:0] OP_H = 3'b111;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLL   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_SLT   = 4'b1000,
    ALU_SLTU  = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_ctrl_e;

  typedef enum logic [3:0] {
    IMM_NONE = 4'b0000,
    IMM_I    = 4'b0001,
    IMM_S    = 4'b0010,
    IMM_B    = 4'b0011,
    IMM_U    = 4'b0100,
    IMM_J    = 4'b0101
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef struct packed {
`ifdef CU_ILLEGAL_DETECT_EN
    logic        illegal_instr;
`endif
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        jump_cond;
    logic [2:0]  jump_cond_type;
    alu_ctrl_e   alu_control;
    logic        alu_src_op1;
    logic        alu_src_op2;
    logic        pc_target_src;
    imm_src_e    imm_src;
    result_src_e result_src;
  } ctrl_t;

endpackage

// File: rtl/control_unit_alu_decoder.sv
// Maps major opcode, func3 and the alt bit to an ALU operation.
module alu_decoder
  import core_pkg::*;
(
  input  logic [2:0] op,
  input  logic [2:0] func3,
  input  logic       alt,
  output alu_ctrl_e  alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    unique case (op)
      OP_A, OP_B: begin
        unique case (func3)
          3'b000: alu_control = (alt && op == OP_A) ? ALU_SUB : ALU_ADD;
          3'b001: alu_control = ALU_SLL;
          3'b010: alu_control = ALU_SLT;
          3'b011: alu_control = ALU_SLTU;
          3'b100: alu_control = ALU_XOR;
          3'b101: alu_control = alt ? ALU_SRA : ALU_SRL;
          3'b110: alu_control = ALU_OR;
          3'b111: alu_control = ALU_AND;
        endcase
      end
      OP_F:    alu_control = ALU_SUB;
      OP_E:    alu_control = func3[0] ? ALU_ADD : ALU_PASSB;
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Main instruction decoder: combinational decode into one output register.
// CU_ILLEGAL_DETECT_EN adds the registered illegal_instr output.
module control_unit
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [2:0]  op,
  input  logic [2:0]  func3,
  input  logic [10:0] func11,
  output logic        reg_write,
  output logic        mem_write,
  output logic        jump,
  output logic        jump_cond,
  output logic [2:0]  jump_cond_type,
  output logic [3:0]  alu_control,
  output logic        alu_src_op1,
  output logic        alu_src_op2,
  output logic        pc_target_src,
  output logic [3:0]  imm_src,
`ifdef CU_ILLEGAL_DETECT_EN
  output logic        illegal_instr,
`endif
  output logic [1:0]  result_src
);

  alu_ctrl_e alu_op;
  ctrl_t     dec;
  ctrl_t     ctrl_d;
  ctrl_t     ctrl_q;

  alu_decoder u_alu_dec (
    .op          (op),
    .func3       (func3),
    .alt         (func11[10]),
    .alu_control (alu_op)
  );

`ifdef CU_ILLEGAL_DETECT_EN
  logic ill;
  assign ill = (op == OP_F && func3[2:1] == 2'b01) ||
               (op == OP_A && func11 != 11'h000 &&
                func11 != 11'h400);
`else
  logic unused_func11;
  assign unused_func11 = ^func11[9:0];
`endif

  always_comb begin
    dec = '0;
    dec.alu_control = alu_op;
    unique case (op)
      OP_A: dec.reg_write = 1'b1;
      OP_B: begin
        dec.reg_write   = 1'b1;
        dec.alu_src_op2 = 1'b1;
        dec.imm_src     = IMM_I;
      end
      OP_C: begin
        dec.reg_write   = 1'b1;
        dec.alu_src_op2 = 1'b1;
        dec.imm_src     = IMM_I;
        dec.result_src  = RES_MEM;
      end
      OP_D: begin
        dec.mem_write   = 1'b1;
        dec.alu_src_op2 = 1'b1;
        dec.imm_src     = IMM_S;
      end
      OP_F: begin
        dec.jump_cond      = 1'b1;
        dec.jump_cond_type = func3;
        dec.imm_src        = IMM_B;
      end
      OP_E: begin
        dec.reg_write   = 1'b1;
        dec.alu_src_op2 = 1'b1;
        dec.alu_src_op1 = func3[0];
        dec.imm_src     = IMM_U;
      end
      OP_G: begin
        dec.jump       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = RES_PC4;
        dec.imm_src    = IMM_J;
      end
      OP_H: begin
        dec.jump          = 1'b1;
        dec.reg_write     = 1'b1;
        dec.result_src    = RES_PC4;
        dec.imm_src       = IMM_I;
        dec.alu_src_op2   = 1'b1;
        dec.pc_target_src = 1'b1;
      end
    endcase
`ifdef CU_ILLEGAL_DETECT_EN
    dec.illegal_instr = ill;
    if (ill) begin
      dec.reg_write = 1'b0;
      dec.mem_write = 1'b0;
      dec.jump      = 1'b0;
      dec.jump_cond = 1'b0;
    end
`endif
  end

  always_comb begin
    ctrl_d = dec;
    if (flush)      ctrl_d = '0;
    else if (stall) ctrl_d = ctrl_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctrl_q <= '0;
    else        ctrl_q <= ctrl_d;
  end

  assign reg_write      = ctrl_q.reg_write;
  assign mem_write      = ctrl_q.mem_write;
  assign jump           = ctrl_q.jump;
  assign jump_cond      = ctrl_q.jump_cond;
  assign jump_cond_type = ctrl_q.jump_cond_type;
  assign alu_control    = ctrl_q.alu_control;
  assign alu_src_op1    = ctrl_q.alu_src_op1;
  assign alu_src_op2    = ctrl_q.alu_src_op2;
  assign pc_target_src  = ctrl_q.pc_target_src;
  assign imm_src        = ctrl_q.imm_src;
  assign result_src     = ctrl_q.result_src;
`ifdef CU_ILLEGAL_DETECT_EN
  assign illegal_instr  = ctrl_q.illegal_instr;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Table-driven bench for control_unit with a scoreboard queue.
// Covers reset, every opcode, stall/flush priority and async reset.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush;
  logic [2:0]  op, func3;
  logic [10:0] func11;
  logic        reg_write, mem_write, jump, jump_cond;
  logic [2:0]  jump_cond_type;
  logic [3:0]  alu_control, imm_src;
  logic        alu_src_op1, alu_src_op2, pc_target_src;
  logic [1:0]  result_src;
  logic        ill_act;

  always #5 clk = ~clk;

  control_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .flush          (flush),
    .op             (op),
    .func3          (func3),
    .func11         (func11),
    .reg_write      (reg_write),
    .mem_write      (mem_write),
    .jump           (jump),
    .jump_cond      (jump_cond),
    .jump_cond_type (jump_cond_type),
    .alu_control    (alu_control),
    .alu_src_op1    (alu_src_op1),
    .alu_src_op2    (alu_src_op2),
    .pc_target_src  (pc_target_src),
    .imm_src        (imm_src),
`ifdef CU_ILLEGAL_DETECT_EN
    .illegal_instr  (ill_act),
`endif
    .result_src     (result_src)
  );

`ifndef CU_ILLEGAL_DETECT_EN
  assign ill_act = 1'b0;
`endif

  logic [19:0] act;
  assign act = {reg_write, mem_write, jump, jump_cond,
                jump_cond_type, alu_control, alu_src_op1,
                alu_src_op2, pc_target_src, imm_src, result_src};

  typedef struct {
    logic        stall;
    logic        flush;
    logic [2:0]  op;
    logic [2:0]  f3;
    logic [10:0] f11;
    logic [19:0] exp;
    logic        ill;
    string       name;
  } vec_t;

  vec_t        vt[$];
  logic [20:0] sb_q[$];
  string       nm_q[$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [19:0] mk(
    input logic rw, mw, j, jc, input logic [2:0] jct,
    input logic [3:0] alu, input logic s1, s2, pt,
    input logic [3:0] imm, input logic [1:0] res);
    return {rw, mw, j, jc, jct, alu, s1, s2, pt, imm, res};
  endfunction

  task automatic add(input logic s, f, input logic [2:0] o, f3,
                     input logic [10:0] f11, input logic [19:0] e,
                     input logic il, input string n);
    vec_t v;
    v.stall = s; v.flush = f; v.op = o; v.f3 = f3; v.f11 = f11;
    v.exp = e; v.ill = il; v.name = n;
    vt.push_back(v);
  endtask

  task automatic check(input string n, input logic [20:0] a,
                       input logic [20:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got ill=%0b ctrl=%05h, want ill=%0b ctrl=%05h",
               n, a[20], a[19:0], e[20], e[19:0]);
    end
  endtask

  // Reference model of the output register; illegal forcing only with the option.
  function automatic logic [20:0] model(input vec_t v,
                                        input logic [20:0] prev);
    logic [20:0] r;
    if (v.flush)      r = '0;
    else if (v.stall) r = prev;
    else begin
      r = {1'b0, v.exp};
`ifdef CU_ILLEGAL_DETECT_EN
      if (v.ill) r = {1'b1, 4'b0000, v.exp[15:0]};
`endif
    end
    return r;
  endfunction

  logic [20:0] prev;

  initial begin
    rst_n = 1'b0; stall = 0; flush = 0;
    op = 0; func3 = 0; func11 = 0;
    #2;
    check("reset_no_edge", {ill_act, act}, '0);

    add(0,0,3'd0,3'd0,11'h000,mk(1,0,0,0,0,4'h0,0,0,0,4'h0,2'd0),0,"opa_add");
    add(0,0,3'd0,3'd0,11'h400,mk(1,0,0,0,0,4'h1,0,0,0,4'h0,2'd0),0,"opa_sub");
    add(0,0,3'd0,3'd1,11'h6DA,mk(1,0,0,0,0,4'h5,0,0,0,4'h0,2'd0),1,"opa_sll_f11");
    add(0,0,3'd0,3'd5,11'h400,mk(1,0,0,0,0,4'h7,0,0,0,4'h0,2'd0),0,"opa_sra");
    add(0,0,3'd0,3'd5,11'h000,mk(1,0,0,0,0,4'h6,0,0,0,4'h0,2'd0),0,"opa_srl");
    add(0,0,3'd0,3'd7,11'h000,mk(1,0,0,0,0,4'h2,0,0,0,4'h0,2'd0),0,"opa_and");
    add(0,0,3'd0,3'd2,11'h000,mk(1,0,0,0,0,4'h8,0,0,0,4'h0,2'd0),0,"opa_slt");
    add(0,0,3'd0,3'd4,11'h000,mk(1,0,0,0,0,4'h4,0,0,0,4'h0,2'd0),0,"opa_xor");
    add(0,0,3'd1,3'd0,11'h400,mk(1,0,0,0,0,4'h0,0,1,0,4'h1,2'd0),0,"opb_add_alt");
    add(0,0,3'd1,3'd5,11'h400,mk(1,0,0,0,0,4'h7,0,1,0,4'h1,2'd0),0,"opb_srai");
    add(0,0,3'd1,3'd3,11'h000,mk(1,0,0,0,0,4'h9,0,1,0,4'h1,2'd0),0,"opb_sltu");
    add(0,0,3'd1,3'd6,11'h000,mk(1,0,0,0,0,4'h3,0,1,0,4'h1,2'd0),0,"opb_or");
    add(0,0,3'd2,3'd2,11'h000,mk(1,0,0,0,0,4'h0,0,1,0,4'h1,2'd1),0,"load");
    add(0,0,3'd3,3'd2,11'h000,mk(0,1,0,0,0,4'h0,0,1,0,4'h2,2'd0),0,"store");
    add(0,0,3'd6,3'd1,11'h6DA,mk(1,0,1,0,0,4'h0,0,0,0,4'h5,2'd2),0,"jal");
    add(0,0,3'd4,3'd0,11'h000,mk(0,0,0,1,3'd0,4'h1,0,0,0,4'h3,2'd0),0,"beq");
    add(0,0,3'd4,3'd7,11'h000,mk(0,0,0,1,3'd7,4'h1,0,0,0,4'h3,2'd0),0,"bgeu");
    add(0,0,3'd4,3'd2,11'h000,mk(0,0,0,1,3'd2,4'h1,0,0,0,4'h3,2'd0),1,"br_bad");
    add(0,0,3'd5,3'd0,11'h000,mk(1,0,0,0,0,4'hA,0,1,0,4'h4,2'd0),0,"lui");
    add(0,0,3'd5,3'd1,11'h000,mk(1,0,0,0,0,4'h0,1,1,0,4'h4,2'd0),0,"auipc");
    add(0,0,3'd7,3'd0,11'h000,mk(1,0,1,0,0,4'h0,0,1,1,4'h1,2'd2),0,"jalr");
    add(0,0,3'd0,3'd6,11'h000,mk(1,0,0,0,0,4'h3,0,0,0,4'h0,2'd0),0,"opa_or");
    add(1,0,3'd3,3'd2,11'h000,'0,0,"stall_hold1");
    add(1,0,3'd6,3'd0,11'h000,'0,0,"stall_hold2");
    add(1,1,3'd7,3'd0,11'h000,'0,0,"stall_flush");
    add(0,0,3'd2,3'd2,11'h000,mk(1,0,0,0,0,4'h0,0,1,0,4'h1,2'd1),0,"load2");
    add(0,1,3'd7,3'd0,11'h000,'0,0,"flush_only");

    @(negedge clk);
    rst_n = 1'b1;
    prev = '0;
    for (int i = 0; i < vt.size(); i++) begin
      stall = vt[i].stall; flush = vt[i].flush;
      op = vt[i].op; func3 = vt[i].f3; func11 = vt[i].f11;
      prev = model(vt[i], prev);
      sb_q.push_back(prev);
      nm_q.push_back(vt[i].name);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty at vector %0d", i);
      end else begin
        check(nm_q.pop_front(), {ill_act, act}, sb_q.pop_front());
      end
      @(negedge clk);
    end

    // Async reset mid-stream, away from any clock edge.
    stall = 0; flush = 0; op = 3'd7; func3 = 0; func11 = 0;
    @(posedge clk); #1;
    check("pre_async_rst", {ill_act, act},
          {1'b0, mk(1,0,1,0,0,4'h0,0,1,1,4'h1,2'd2)});
    #2 rst_n = 1'b0;
    #1 check("async_rst", {ill_act, act}, '0);
    @(posedge clk); #1;
    check("rst_held_edge", {ill_act, act}, '0);
    @(negedge clk);
    rst_n = 1'b1; op = 3'd3; func3 = 3'd2;
    @(posedge clk); #1;
    check("post_rst_store", {ill_act, act},
          {1'b0, mk(0,1,0,0,0,4'h0,0,1,0,4'h2,2'd0)});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
